// File: rtl/rs_pkg.sv
// Shared types and sizing for the RS(7,5) GF(8) decoder front/back end.
package rs_pkg;

   localparam int unsigned N      = 7;
   localparam int unsigned K      = 5;
   localparam int unsigned SYM_W  = 3;
   localparam int unsigned CNT_W  = $clog2(N) + 1;
   localparam int unsigned WAIT_W = 4;

   typedef logic [SYM_W-1:0]   symbol_t;
   typedef logic [N*SYM_W-1:0] codeword_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   typedef enum logic [1:0] {
      COLLECT,
      LAUNCH,
      WAIT,
      EMIT
   } seq_state_t;

endpackage

// File: rtl/rs_decode_sequencer.sv
// Collects one codeword from a symbol stream, runs it through the external
// combinational decoder for DEC_LATENCY cycles, then streams the result out.
module rs_decode_sequencer
   import rs_pkg::*;
#(
   parameter int unsigned DEC_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SYM_W-1:0]     in_sym,
   input  logic                 in_last,
   output logic                 dec_reset,
   output logic [N*SYM_W-1:0]   dec_codeword,
   input  logic [N*SYM_W-1:0]   dec_corrected,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SYM_W-1:0]     out_sym,
   output logic                 out_last,
   output logic                 frame_err,
   output logic                 busy
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic              r_in_ready;
   logic              r_drop;
   cnt_t              r_sym_cnt;
   cnt_t              r_out_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   codeword_t         r_cw;
   codeword_t         r_out;
   codeword_t         r_dec_cw;
   logic              r_dec_reset;
   logic              r_frame_err;

   logic w_in_hs;
   logic w_out_hs;
   cnt_t w_sym_cnt_inc;
   logic w_good;
   logic w_short;
   logic w_long;
   logic w_out_end;

   assign w_in_hs       = (r_state == COLLECT) && in_valid && r_in_ready;
   assign w_out_hs      = (r_state == EMIT) && out_ready;
   assign w_sym_cnt_inc = r_sym_cnt + cnt_t'(1);
   assign w_good        = w_in_hs && !r_drop && in_last && (w_sym_cnt_inc == cnt_t'(N));
   assign w_short       = w_in_hs && !r_drop && in_last && (w_sym_cnt_inc != cnt_t'(N));
   assign w_long        = w_in_hs && !r_drop && !in_last && (w_sym_cnt_inc == cnt_t'(N));
   assign w_out_end     = w_out_hs && (r_out_cnt == cnt_t'(N - 1));

   assign in_ready     = r_in_ready;
   assign dec_reset    = r_dec_reset;
   assign dec_codeword = r_dec_cw;
   assign frame_err    = r_frame_err;

   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      out_sym     = '0;
      out_last    = 1'b0;
      busy        = (r_state != COLLECT) || (r_sym_cnt != '0);
      case (r_state)
         COLLECT: if (w_good) w_state_nxt = LAUNCH;
         LAUNCH:  w_state_nxt = WAIT;
         WAIT:    if (r_wait_cnt == '0) w_state_nxt = EMIT;
         EMIT: begin
            out_valid = 1'b1;
            out_sym   = r_out[N*SYM_W-1 -: SYM_W];
            out_last  = (r_out_cnt == cnt_t'(N - 1));
            if (w_out_end) w_state_nxt = COLLECT;
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   // in_ready is registered off the next state so it is already low in the
   // cycle after the accepting beat and already high after the final output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= COLLECT;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == COLLECT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop      <= 1'b0;
         r_sym_cnt   <= '0;
         r_out_cnt   <= '0;
         r_wait_cnt  <= '0;
         r_cw        <= '0;
         r_out       <= '0;
         r_dec_cw    <= '0;
         r_dec_reset <= 1'b1;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_short || w_long;

         // A long frame leaves r_drop set so the tail up to in_last is swallowed.
         if (w_in_hs) begin
            if (r_drop) begin
               if (in_last) r_drop <= 1'b0;
            end else if (w_short || w_long) begin
               r_sym_cnt <= '0;
               r_cw      <= '0;
               r_drop    <= w_long;
            end else begin
               r_cw      <= {r_cw[N*SYM_W-SYM_W-1:0], in_sym};
               r_sym_cnt <= w_good ? '0 : w_sym_cnt_inc;
            end
         end

         case (r_state)
            LAUNCH: begin
               r_dec_cw    <= r_cw;
               r_dec_reset <= 1'b0;
               r_wait_cnt  <= WAIT_W'(DEC_LATENCY - 1);
            end
            WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_out       <= dec_corrected;
                  r_dec_reset <= 1'b1;
                  r_out_cnt   <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
               end
            end
            EMIT: begin
               if (w_out_hs) begin
                  r_out     <= r_out << SYM_W;
                  r_out_cnt <= w_out_end ? '0 : r_out_cnt + cnt_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Randomised self-checking bench for rs_decode_sequencer with a decoder stub
// that corrupts the codeword until DEC_LATENCY cycles have elapsed.
module tb_rs_decode_sequencer;
   import rs_pkg::*;

   localparam int unsigned DL = 2;

   logic      clk = 1'b0;
   logic      reset = 1'b0;
   logic      in_valid = 1'b0;
   logic      in_last = 1'b0;
   logic      out_ready = 1'b1;
   symbol_t   in_sym = '0;
   codeword_t dec_corrected;
   logic      in_ready, dec_reset, out_valid, out_last, frame_err, busy;
   codeword_t dec_codeword;
   symbol_t   out_sym;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rs_decode_sequencer #(.DEC_LATENCY(DL)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
      .dec_reset(dec_reset), .dec_codeword(dec_codeword), .dec_corrected(dec_corrected),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
      .frame_err(frame_err), .busy(busy)
   );

   // decoder stub: wrong answer until the codeword has been applied DL cycles
   codeword_t   mask = '0;
   int unsigned low_cyc;
   always @(posedge clk or posedge reset)
      if (reset || dec_reset) low_cyc <= 0;
      else                    low_cyc <= low_cyc + 1;
   assign dec_corrected = (!dec_reset && low_cyc >= DL - 1) ? (dec_codeword ^ mask)
                                                            : ~(dec_codeword ^ mask);

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // behavioural model state
   typedef struct { symbol_t s; logic l; } ob_t;
   symbol_t   buf_q[$];
   ob_t       exp_q[$];
   symbol_t   log_q[$];
   logic      log_last_q[$];
   logic      drop_m = 1'b0, inflight = 1'b0, ready_ok = 1'b0, exp_err = 1'b0;
   codeword_t exp_cw = '0, cw_seen = '0;
   int        low_run = 0, last_low = 0, low_events = 0, err_act = 0, out_hs_frame = 0;
   logic      prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
   symbol_t   prev_sym = '0;
   logic      rnd_ready = 1'b0;

   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (reset) begin
         check("rst in_ready", in_ready, 0);
         check("rst dec_reset", dec_reset, 1);
         check("rst dec_codeword", dec_codeword, 0);
         check("rst out_valid", out_valid, 0);
         check("rst out_sym", out_sym, 0);
         check("rst out_last", out_last, 0);
         check("rst frame_err", frame_err, 0);
         check("rst busy", busy, 0);
         buf_q.delete();
         exp_q.delete();
         drop_m = 0; inflight = 0; ready_ok = 0; exp_err = 0;
         low_run = 0; prev_valid = 0; out_hs_frame = 0;
      end else begin
         check("in_ready", in_ready, ready_ok && !inflight);
         check("frame_err", frame_err, exp_err);
         check("busy", busy, inflight || buf_q.size() != 0);
         if (frame_err) err_act++;
         if (!inflight) begin
            check("idle out_valid", out_valid, 0);
            check("idle dec_reset", dec_reset, 1);
         end
         if (!dec_reset) begin
            if (low_run == 0) low_events++;
            check("dec_codeword", dec_codeword, exp_cw);
            cw_seen = dec_codeword;
            low_run++;
         end else if (low_run > 0) begin
            check("dec_reset low cycles", low_run, DL);
            last_low = low_run;
            low_run = 0;
         end
         if (prev_valid && !prev_ready) begin
            check("stall out_valid", out_valid, 1);
            check("stall out_sym", out_sym, prev_sym);
            check("stall out_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected output beat");
            end else begin
               ob_t e;
               e = exp_q.pop_front();
               check("out_sym", out_sym, e.s);
               check("out_last", out_last, e.l);
               log_q.push_back(out_sym);
               log_last_q.push_back(out_last);
               out_hs_frame++;
               if (e.l) begin
                  inflight = 0;
                  out_hs_frame = 0;
               end
            end
         end
         prev_valid = out_valid; prev_ready = out_ready;
         prev_sym = out_sym; prev_last = out_last;

         exp_err = 0;
         if (in_valid && in_ready) begin
            if (drop_m) begin
               if (in_last) drop_m = 0;
            end else begin
               buf_q.push_back(in_sym);
               if (in_last) begin
                  if (buf_q.size() == N) begin
                     codeword_t w, c;
                     w = '0;
                     foreach (buf_q[i]) w = (w << SYM_W) | codeword_t'(buf_q[i]);
                     exp_cw = w;
                     c = w ^ mask;
                     for (int i = 0; i < N; i++)
                        exp_q.push_back('{c[(N-1-i)*SYM_W +: SYM_W], (i == N - 1)});
                     inflight = 1;
                  end else begin
                     exp_err = 1;
                  end
                  buf_q.delete();
               end else if (buf_q.size() == N) begin
                  exp_err = 1;
                  drop_m = 1;
                  buf_q.delete();
               end
            end
         end
         ready_ok = 1;
      end
   end

   // stimulus helpers
   bit gaps = 0;

   task automatic send_frame(input symbol_t syms[16], input int len);
      for (int b = 0; b < len; b++) begin
         bit ok;
         in_valid = 1; in_sym = syms[b]; in_last = (b == len - 1);
         ok = 0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
         end
         @(posedge clk); #1;
         in_valid = 0; in_last = 0;
         if (!ok) begin fail_now("in_ready timeout"); return; end
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 500; c++) begin
         if (!inflight && exp_q.size() == 0) return;
         @(posedge clk); #1;
      end
      fail_now("frame completion timeout");
   endtask

   task automatic check_log(input string nm, input symbol_t e[7]);
      check({nm, " count"}, log_q.size(), 7);
      for (int i = 0; i < 7; i++)
         if (i < log_q.size()) check(nm, log_q[i], e[i]);
   endtask

   task automatic rand_frame(output symbol_t s[16]);
      for (int i = 0; i < 16; i++) s[i] = symbol_t'($urandom);
   endtask

   initial begin
      symbol_t f1[16], fr[16];
      symbol_t exp1[7], exp2[7];
      logic [6:0] lastv;
      int e0, l0;

      exp1 = '{3'd0, 3'd1, 3'd6, 3'd3, 3'd1, 3'd7, 3'd4};
      exp2 = '{3'd0, 3'd1, 3'd6, 3'd3, 3'd3, 3'd7, 3'd4};
      foreach (f1[i]) f1[i] = '0;
      for (int i = 0; i < 7; i++) f1[i] = exp1[i];

      #1 reset = 1;
      repeat (3) @(posedge clk);
      #1;
      check("lit reset in_ready", in_ready, 0);
      check("lit reset dec_reset", dec_reset, 1);
      reset = 0;
      @(posedge clk); #1;

      // 1: basic frame
      mask = '0; log_q.delete(); log_last_q.delete();
      send_frame(f1, 7); wait_idle();
      check("lit t1 codeword", cw_seen, 21'o0163174);
      check("lit t1 low cycles", last_low, 2);
      check_log("lit t1 seq", exp1);
      lastv = '0;
      foreach (log_last_q[i]) if (i < 7) lastv[i] = log_last_q[i];
      check("lit t1 last pattern", lastv, 7'b1000000);

      // 2: one corrected symbol
      mask = 21'o0000200; log_q.delete();
      send_frame(f1, 7); wait_idle();
      check_log("lit t2 seq", exp2);

      // 3: backpressure
      mask = '0; rnd_ready = 1; log_q.delete();
      send_frame(f1, 7); wait_idle();
      check_log("lit t3 seq", exp1);
      rnd_ready = 0;

      // 4: short frame then good frame
      e0 = err_act; l0 = low_events;
      fr = f1; fr[0] = 3'd5;
      send_frame(fr, 4);
      repeat (3) begin @(posedge clk); #1; end
      check("lit t4 frame_err count", err_act - e0, 1);
      check("lit t4 no decode", low_events - l0, 0);
      log_q.delete(); rand_frame(fr); mask = codeword_t'($urandom);
      send_frame(fr, 7); wait_idle();
      check("lit t4 next frame beats", log_q.size(), 7);

      // 5: long frame then good frame
      e0 = err_act; l0 = low_events; log_q.delete();
      rand_frame(fr);
      send_frame(fr, 8);
      repeat (3) begin @(posedge clk); #1; end
      check("lit t5 frame_err count", err_act - e0, 1);
      check("lit t5 no decode", low_events - l0, 0);
      check("lit t5 no output", log_q.size(), 0);
      mask = '0;
      send_frame(f1, 7); wait_idle();
      check_log("lit t5 next seq", exp1);

      // 6: reset during EMIT
      send_frame(f1, 7);
      begin
         bit hit = 0;
         for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (out_hs_frame >= 2) begin hit = 1; break; end
         end
         if (!hit) fail_now("t6 emit timeout");
      end
      reset = 1;
      #1;
      check("lit t6 out_valid", out_valid, 0);
      check("lit t6 out_last", out_last, 0);
      check("lit t6 out_sym", out_sym, 0);
      check("lit t6 in_ready", in_ready, 0);
      check("lit t6 dec_reset", dec_reset, 1);
      check("lit t6 busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(posedge clk); #1;
      log_q.delete(); mask = 21'o0000200;
      send_frame(f1, 7); wait_idle();
      check_log("lit t6 next seq", exp2);

      // randomised mix of good, short and long frames
      gaps = 1;
      for (int it = 0; it < 40; it++) begin
         int kind;
         kind = $urandom_range(0, 9);
         rnd_ready = $urandom_range(0, 1) == 1;
         rand_frame(fr);
         if (kind < 7) begin
            mask = codeword_t'($urandom);
            send_frame(fr, 7); wait_idle();
         end else if (kind < 9) begin
            send_frame(fr, $urandom_range(1, 6));
         end else begin
            send_frame(fr, $urandom_range(8, 10));
         end
      end
      rnd_ready = 0;
      wait_idle();
      repeat (4) begin @(posedge clk); #1; end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1);
   end

endmodule
